// File: rtl/gate_exerciser_pkg.sv
// Shared definitions for the gate exerciser family: FSM states, the fixed
// vector order applied to each gate, and truth tables for common 2-input gates.
package gate_exerciser_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // {A,B} applied to the gate under test, in order
    localparam logic [1:0] VEC0 = 2'b11;
    localparam logic [1:0] VEC1 = 2'b01;
    localparam logic [1:0] VEC2 = 2'b10;
    localparam logic [1:0] VEC3 = 2'b00;

    // Truth tables indexed by {A,B}
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    localparam int SETTLE_W = 8;

    // Map a vector index onto the {A,B} pair it applies
    function automatic logic [1:0] vec_ab(input logic [1:0] v);
        case (v)
            2'd0:    vec_ab = VEC0;
            2'd1:    vec_ab = VEC1;
            2'd2:    vec_ab = VEC2;
            default: vec_ab = VEC3;
        endcase
    endfunction

    // Put one bit onto lane g of a 4-gate bus, all other lanes low
    function automatic logic [3:0] lane(input logic [1:0] g, input logic val);
        lane    = 4'b0000;
        lane[g] = val;
    endfunction

endpackage

// File: rtl/gate_exerciser_settle_timer.sv
// Loadable down-counter. Loaded with N-1, it raises tc_o during the N-th
// cycle after the load, so the owner acts on exactly the N-th edge.
module gate_exerciser_settle_timer
    import gate_exerciser_pkg::*;
#(
    parameter int W = SETTLE_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over counting; the counter parks at zero until reloaded
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = en_i && (count_q == '0);

endmodule

// File: rtl/gate_exerciser.sv
// Drives each gate of a quad 2-input device through four {A,B} vectors,
// checks Y after a settle interval and reports pass or the first failure.
//
// Handshake: START is a level request, accepted only in IDLE or DONE on a
// rising edge; while BUSY=1 it is ignored. DONE stays high with PASS and
// FAIL_GATE/FAIL_VEC stable until the next accepted START or RST, so a held
// START deliberately re-triggers a run on the edge after DONE rises.
module gate_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECT        = TT_OR
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] Y,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [1:0] FAIL_GATE,
    output logic [1:0] FAIL_VEC,
    output state_t     dbg_state_o
);

    localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [1:0] gate_q;
    logic [1:0] vec_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [1:0] fail_gate_q;
    logic [1:0] fail_vec_q;

    logic       tc;
    logic       accept;
    logic       y_bad;
    logic       last_vec;
    logic       advance;
    logic [1:0] vec_d;
    logic [1:0] gate_d;
    logic [1:0] ab_cur;
    logic [1:0] ab_d;

    // Compare and sequencing decode for the vector currently on the pins
    always_comb begin
        ab_cur   = vec_ab(vec_q);
        y_bad    = (Y[gate_q] !== EXPECT[ab_cur]);
        last_vec = (gate_q == 2'd3) && (vec_q == 2'd3);
        accept   = START && (state_q != S_RUN);
        advance  = (state_q == S_RUN) && tc && !y_bad && !last_vec;
        vec_d    = vec_q + 2'd1;
        gate_d   = (vec_q == 2'd3) ? gate_q + 2'd1 : gate_q;
        ab_d     = vec_ab(vec_d);
    end

    gate_exerciser_settle_timer #(
        .W(SETTLE_W)
    ) u_settle (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (accept || advance),
        .load_val_i (LOAD_VAL),
        .en_i       (state_q == S_RUN),
        .tc_o       (tc)
    );

    // Run FSM with registered drive and result outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            gate_q      <= 2'd0;
            vec_q       <= 2'd0;
            a_q         <= 4'b0000;
            b_q         <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_gate_q <= 2'd0;
            fail_vec_q  <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        state_q     <= S_RUN;
                        gate_q      <= 2'd0;
                        vec_q       <= 2'd0;
                        a_q         <= lane(2'd0, VEC0[1]);
                        b_q         <= lane(2'd0, VEC0[0]);
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        fail_gate_q <= 2'd0;
                        fail_vec_q  <= 2'd0;
                    end
                end
                S_RUN: begin
                    if (tc) begin
                        if (y_bad || last_vec) begin
                            state_q <= S_DONE;
                            a_q     <= 4'b0000;
                            b_q     <= 4'b0000;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= !y_bad;
                            if (y_bad) begin
                                fail_gate_q <= gate_q;
                                fail_vec_q  <= vec_q;
                            end
                        end else begin
                            vec_q  <= vec_d;
                            gate_q <= gate_d;
                            a_q    <= lane(gate_d, ab_d[1]);
                            b_q    <= lane(gate_d, ab_d[0]);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign A           = a_q;
    assign B           = b_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign PASS        = pass_q;
    assign FAIL_GATE   = fail_gate_q;
    assign FAIL_VEC    = fail_vec_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: an OR-device model with stuck-at
// overrides on one instance, and a mismatched truth table on a second.
module tb_gate_exerciser;
    import gate_exerciser_pkg::*;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // ---------------- instance 1: default OR, SETTLE=2 ----------------
    logic       start1 = 1'b0;
    logic [3:0] sa0 = 4'b0000;
    logic [3:0] sa1 = 4'b0000;
    logic [3:0] y1, a1, b1;
    logic       busy1, done1, pass1;
    logic [1:0] fg1, fv1;
    state_t     st1;

    assign y1 = ((a1 | b1) & ~sa0) | sa1;

    gate_exerciser dut1 (
        .CLK         (CLK),
        .RST         (RST),
        .START       (start1),
        .Y           (y1),
        .A           (a1),
        .B           (b1),
        .BUSY        (busy1),
        .DONE        (done1),
        .PASS        (pass1),
        .FAIL_GATE   (fg1),
        .FAIL_VEC    (fv1),
        .dbg_state_o (st1)
    );

    // ---------------- instance 2: AND table vs OR device, SETTLE=3 ------
    logic       start2 = 1'b0;
    logic [3:0] y2, a2, b2;
    logic       busy2, done2, pass2;
    logic [1:0] fg2, fv2;
    state_t     st2;

    assign y2 = a2 | b2;

    gate_exerciser #(
        .SETTLE_CYCLES (3),
        .EXPECT        (TT_AND)
    ) dut2 (
        .CLK         (CLK),
        .RST         (RST),
        .START       (start2),
        .Y           (y2),
        .A           (a2),
        .B           (b2),
        .BUSY        (busy2),
        .DONE        (done2),
        .PASS        (pass2),
        .FAIL_GATE   (fg2),
        .FAIL_VEC    (fv2),
        .dbg_state_o (st2)
    );

    // ---------------- bookkeeping ----------------
    int vectors     = 0;
    int miscompares = 0;
    localparam int BUDGET = 200;
    logic [1:0] vtab [4] = '{2'b11, 2'b01, 2'b10, 2'b00};

    // ---------------- driver tasks ----------------
    task automatic pulse_start1();
        @(negedge CLK) start1 = 1'b1;
        @(negedge CLK) start1 = 1'b0;
    endtask

    // Steps edges until DONE (bounded), tracking A/B against the drive model
    // for SETTLE=2. Must be entered between the accepting edge and the next.
    task automatic wait_done1(output int n, output logic ab_bad,
                              output logic busy_bad, output logic [3:0] ab_seen);
        int idx;
        logic [3:0] ea, eb;
        n = 0; ab_bad = 1'b0; busy_bad = 1'b0; ab_seen = 4'b0000;
        while (done1 !== 1'b1 && n < BUDGET) begin
            idx = n / 2;
            ea = 4'b0000; eb = 4'b0000;
            if (idx < 16) begin
                ea[idx / 4] = vtab[idx % 4][1];
                eb[idx / 4] = vtab[idx % 4][0];
            end
            if (a1 !== ea || b1 !== eb) ab_bad = 1'b1;
            if (busy1 !== 1'b1) busy_bad = 1'b1;
            ab_seen = ab_seen | a1 | b1;
            @(posedge CLK); #1;
            n++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #12;
        vectors++;
        if ({a1, b1, busy1, done1, pass1, fg1, fv1} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0", {a1, b1, busy1, done1, pass1, fg1, fv1});
        end
        vectors++;
        if (st1 !== S_IDLE || st2 !== S_IDLE) begin
            miscompares++;
            $display("FAIL reset_state got %0d/%0d want 0", st1, st2);
        end
        @(negedge CLK) RST = 1'b0;
        repeat (2) @(negedge CLK);
        vectors++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_start got done=%b busy=%b want 0 0", done1, busy1);
        end
    endtask

    task automatic test_normal_or();
        int n; logic abb, bb; logic [3:0] seen;
        pulse_start1();
        wait_done1(n, abb, bb, seen);
        vectors++;
        if (n !== 32) begin
            miscompares++;
            $display("FAIL or_latency got %0d want 32", n);
        end
        vectors++;
        if (abb !== 1'b0 || bb !== 1'b0) begin
            miscompares++;
            $display("FAIL or_drive_seq got ab_bad=%b busy_bad=%b want 0 0", abb, bb);
        end
        vectors++;
        if ({pass1, fg1, fv1, a1, b1, busy1} !== {1'b1, 2'd0, 2'd0, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL or_result got pass=%b g=%0d v=%0d a=%b b=%b busy=%b want 1 0 0 0000 0000 0",
                     pass1, fg1, fv1, a1, b1, busy1);
        end
        repeat (3) @(negedge CLK);
        vectors++;
        if (done1 !== 1'b1 || pass1 !== 1'b1 || st1 !== S_DONE) begin
            miscompares++;
            $display("FAIL or_done_hold got done=%b pass=%b st=%0d want 1 1 2", done1, pass1, st1);
        end
    endtask

    task automatic test_stuck0();
        int n; logic abb, bb; logic [3:0] seen;
        sa0 = 4'b0100;
        pulse_start1();
        wait_done1(n, abb, bb, seen);
        vectors++;
        if (n !== 18 || abb !== 1'b0) begin
            miscompares++;
            $display("FAIL sa0_latency got %0d ab_bad=%b want 18 0", n, abb);
        end
        vectors++;
        if ({pass1, fg1, fv1} !== {1'b0, 2'd2, 2'd0}) begin
            miscompares++;
            $display("FAIL sa0_result got pass=%b g=%0d v=%0d want 0 2 0", pass1, fg1, fv1);
        end
        vectors++;
        if (seen[3] !== 1'b0 || {a1, b1} !== 8'h00) begin
            miscompares++;
            $display("FAIL sa0_gate3_untouched got seen=%b a=%b b=%b want 0xxx 0000 0000", seen, a1, b1);
        end
        sa0 = 4'b0000;
    endtask

    task automatic test_stuck1();
        int n; logic abb, bb; logic [3:0] seen;
        sa1 = 4'b0001;
        pulse_start1();
        wait_done1(n, abb, bb, seen);
        vectors++;
        if (n !== 8) begin
            miscompares++;
            $display("FAIL sa1_latency got %0d want 8", n);
        end
        vectors++;
        if ({pass1, fg1, fv1} !== {1'b0, 2'd0, 2'd3}) begin
            miscompares++;
            $display("FAIL sa1_result got pass=%b g=%0d v=%0d want 0 0 3", pass1, fg1, fv1);
        end
        sa1 = 4'b0000;
    endtask

    task automatic test_wrong_table();
        int n;
        @(negedge CLK) start2 = 1'b1;
        @(negedge CLK) start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < BUDGET) begin
            @(posedge CLK); #1;
            n++;
        end
        vectors++;
        if (n !== 6) begin
            miscompares++;
            $display("FAIL and_latency got %0d want 6", n);
        end
        vectors++;
        if ({pass2, fg2, fv2, a2, b2} !== {1'b0, 2'd0, 2'd1, 8'h00}) begin
            miscompares++;
            $display("FAIL and_result got pass=%b g=%0d v=%0d a=%b b=%b want 0 0 1 0000 0000",
                     pass2, fg2, fv2, a2, b2);
        end
    endtask

    task automatic test_reset_mid_run();
        int n; logic abb, bb; logic [3:0] seen;
        pulse_start1();
        repeat (9) @(posedge CLK);
        #3;
        vectors++;
        if (busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun_busy got %b want 1", busy1);
        end
        RST = 1'b1;
        #1;
        vectors++;
        if ({a1, b1, busy1, done1, pass1, fg1, fv1} !== 15'd0 || st1 !== S_IDLE) begin
            miscompares++;
            $display("FAIL async_reset got %h st=%0d want 0 0",
                     {a1, b1, busy1, done1, pass1, fg1, fv1}, st1);
        end
        @(negedge CLK) RST = 1'b0;
        pulse_start1();
        wait_done1(n, abb, bb, seen);
        vectors++;
        if (n !== 32 || pass1 !== 1'b1 || abb !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_run got n=%0d pass=%b ab_bad=%b want 32 1 0", n, pass1, abb);
        end
    endtask

    task automatic test_start_during_run();
        int n; logic abb, bb; logic [3:0] seen;
        pulse_start1();
        n = 0;
        while (done1 !== 1'b1 && n < BUDGET) begin
            if (n == 5) start1 = 1'b1;
            if (n == 6) start1 = 1'b0;
            @(posedge CLK); #1;
            n++;
        end
        vectors++;
        if (n !== 32 || pass1 !== 1'b1) begin
            miscompares++;
            $display("FAIL start_in_run got n=%0d pass=%b want 32 1", n, pass1);
        end
        @(negedge CLK) start1 = 1'b1;
        @(posedge CLK); #1;
        start1 = 1'b0;
        vectors++;
        if (done1 !== 1'b0 || busy1 !== 1'b1 || pass1 !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_from_done got done=%b busy=%b pass=%b want 0 1 0", done1, busy1, pass1);
        end
        wait_done1(n, abb, bb, seen);
        vectors++;
        if (n !== 32 || {pass1, fg1, fv1} !== {1'b1, 2'd0, 2'd0} || abb !== 1'b0) begin
            miscompares++;
            $display("FAIL repeat_run got n=%0d pass=%b g=%0d v=%0d want 32 1 0 0", n, pass1, fg1, fv1);
        end
    endtask

    task automatic test_back_to_back();
        int n; logic abb, bb; logic [3:0] seen;
        @(negedge CLK) start1 = 1'b1;
        @(negedge CLK);
        wait_done1(n, abb, bb, seen);
        vectors++;
        if (n !== 32 || pass1 !== 1'b1) begin
            miscompares++;
            $display("FAIL held_start_run got n=%0d pass=%b want 32 1", n, pass1);
        end
        @(posedge CLK); #1;
        start1 = 1'b0;
        vectors++;
        if (done1 !== 1'b0 || busy1 !== 1'b1 || st1 !== S_RUN) begin
            miscompares++;
            $display("FAIL held_start_retrigger got done=%b busy=%b st=%0d want 0 1 1", done1, busy1, st1);
        end
        wait_done1(n, abb, bb, seen);
        vectors++;
        if (n !== 32 || pass1 !== 1'b1 || abb !== 1'b0) begin
            miscompares++;
            $display("FAIL retrigger_run got n=%0d pass=%b ab_bad=%b want 32 1 0", n, pass1, abb);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_normal_or();
        test_stuck0();
        test_stuck1();
        test_wrong_table();
        test_reset_mid_run();
        test_start_during_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- Synthesizable initiator that exercises a quad 2-input gate device (MOD_74x32_4 and siblings).
- Drives A/B of one gate at a time through all four input combinations, waits a settle interval, then checks Y against a parameterised truth table.
- Reports pass, or the first failing gate and vector.
- Sits opposite the device-under-test on its A/B/Y pins, for on-board self-test and for regressing gate models without a hand-written bench per chip.

Parameters:
- SETTLE_CYCLES, 2: clock cycles each vector is held before Y is sampled; legal range 1..255.
- EXPECT, 4'b1110: truth table indexed by {A,B}, so EXPECT[{a,b}] is the required Y. The default is OR.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  begin a run; sampled only in IDLE or DONE.
- Y  in  4  DUT outputs; Y[0] is gate 1 … Y[3] is gate 4.
- A  out  4  DUT A inputs; A[0] is gate 1.
- B  out  4  DUT B inputs.
- BUSY  out  1  run in progress.
- DONE  out  1  run finished; held until next START or RST.
- PASS  out  1  valid when DONE=1; 1 means all 16 checks matched.
- FAIL_GATE  out  2  index (0..3) of the first failing gate; 0 if PASS.
- FAIL_VEC  out  2  index of the first failing vector (0:11, 1:01, 2:10, 3:00); 0 if PASS.

Behaviour:
- Reset (asynchronous, any state): state = IDLE. A, B, BUSY, DONE, PASS, FAIL_GATE and FAIL_VEC are all 0. Gate, vector and settle counters are 0.
- States: IDLE, RUN, DONE.
- IDLE or DONE with START=1 at edge t0:
  - Enter RUN, BUSY=1, DONE=0, PASS=0, FAIL_* = 0.
  - Gate=0, vector=0, and A/B for that vector are driven from t0.
- Vector order per gate: {A,B} = 11, 01, 10, 00. Gates are exercised in order 0,1,2,3.
- Drive rule: only A[g]/B[g] of the gate under test carry the vector. All other A/B bits are 0.
- Timing:
  - Each vector is held for exactly SETTLE_CYCLES cycles.
  - At the SETTLE_CYCLES-th edge after it was applied, Y[g] is compared with EXPECT[{A[g],B[g]}], using 4-state inequality so X/Z counts as a mismatch.
  - Y bits of other gates are ignored.
- Match, not last vector: on the same edge, advance to the next vector (vector wraps 3→0 and gate increments). No idle cycle between vectors.
- Match on the last vector (gate 3, vector 3): enter DONE. BUSY=0, DONE=1, PASS=1, A=B=0.
- Mismatch: enter DONE on that edge. BUSY=0, DONE=1, PASS=0, FAIL_GATE=g, FAIL_VEC=v, A=B=0. The remaining vectors are skipped.
- Full-pass latency: 16×SETTLE_CYCLES edges from t0 to DONE (32 at the default).
- A failure on gate g, vector v is reported at edge t0 + (4g+v+1)×SETTLE_CYCLES.
- START while in RUN is ignored; the run is not restarted.
- START in DONE restarts immediately, with the same behaviour as from IDLE.
- START held high: one run per acceptance. After DONE, a run re-triggers on the next edge while START remains high; this is intentional.
- RST asserted mid-run aborts to the reset state immediately, without waiting for a clock edge. No partial result is retained.
- Counter widths: 2-bit gate, 2-bit vector, 8-bit settle. The settle counter reloads on every vector advance.

Decomposition:
- Shared include header, alongside the existing test macros, holds:
  - State encodings: S_IDLE, S_RUN, S_DONE.
  - Vector order table: VEC0=2'b11, VEC1=2'b01, VEC2=2'b10, VEC3=2'b00.
  - Truth-table constants: TT_OR=4'b1110, TT_AND=4'b1000, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110.
- One sub-module, settle_timer:
  - Loadable down-counter with a terminal-count pulse.
  - Reused by later exercisers (flip-flop and counter chip checkers).
- The top level holds the FSM, the vector/gate counters, the drive decode and the compare.

Test Plan:
- Normal OR run: connect to MOD_74x32_4, default parameters, pulse START → BUSY for 32 cycles, then DONE=1, PASS=1, FAIL_GATE=0, FAIL_VEC=0, A=B=4'b0000.
- Stuck-at-0: bench forces Y[2]=0 → DONE at cycle 18 after START, PASS=0, FAIL_GATE=2, FAIL_VEC=0. A/B never drove gate 3.
- Stuck-at-1: Y[0] forced to 1 → DONE at cycle 8, PASS=0, FAIL_GATE=0, FAIL_VEC=3.
- Wrong truth table: EXPECT=TT_AND against the OR device with SETTLE_CYCLES=3 → first mismatch at gate 0, vector 1 (input 01). DONE at cycle 6, FAIL_VEC=1.
- Reset mid-run: assert RST at cycle 10 of a run, mid-cycle → all outputs 0 immediately, with no clock edge needed. Release, then pulse START → clean full run, PASS=1 at cycle 32.
- START during RUN: pulse START at cycle 5 → ignored, DONE still at cycle 32. A second START while DONE=1 → DONE clears on the next edge and the run repeats with an identical result.
